vdf_sq_sequencer: RTL

Job-level controller for the `redun_mont` repeated-squaring datapath. It accepts a start value and an iteration count, launches the free-running squarer, and counts its per-iteration result strobes. After the requested number of squarings it captures the result, halts the datapath by holding it in reset, and returns the result to the host through a valid/ready handshake. It sits between the host/PCIe shell and `redun_mont`. It also provides periodic checkpoint outputs, a watchdog, and abort.

---
 rtl/redun_mont_pkg.sv | 26 ++
 rtl/vdf_sq_sequencer_wdog_cnt.sv | 25 ++
 rtl/vdf_sq_sequencer.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/redun_mont_pkg.sv
// Shared types for the redun_mont datapath and its job sequencer.
package redun_mont_pkg;

  localparam int unsigned REDUN_BITS = 64;
  typedef logic [REDUN_BITS-1:0] redun0_t;

  localparam int unsigned DEF_CNT_BITS     = 64;
  localparam int unsigned DEF_CHK_LOG2     = 20;
  localparam int unsigned DEF_WDOG_CYCLES  = 4096;
  localparam int unsigned DEF_FLUSH_CYCLES = 16;

  typedef enum logic [1:0] {
    SeqOk    = 2'd0,
    SeqWdog  = 2'd1,
    SeqAbort = 2'd2
  } seq_err_t;

  typedef enum logic [4:0] {
    StIdle   = 5'b00001,
    StLoad   = 5'b00010,
    StRun    = 5'b00100,
    StResult = 5'b01000,
    StFlush  = 5'b10000
  } seq_state_t;

endpackage

// File: rtl/vdf_sq_sequencer_wdog_cnt.sv
// Clearable up-counter that saturates at TERM and flags it; used for watchdog and flush timing.
module seq_wdog_cnt #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned TERM  = 255
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clr,
  input  logic i_inc,
  output logic o_term
);

  logic [WIDTH-1:0] cnt_q;

  assign o_term = (cnt_q == WIDTH'(TERM));

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) begin
      cnt_q <= '0;
    end else if (i_inc && !o_term) begin
      cnt_q <= cnt_q + WIDTH'(1);
    end
  end

endmodule

// File: rtl/vdf_sq_sequencer.sv
// Job controller for the redun_mont squarer: launch, count strobes, checkpoint, watchdog,
// abort, result handshake and post-job datapath flush.
module vdf_sq_sequencer
  import redun_mont_pkg::*;
#(
  parameter int unsigned CNT_BITS     = DEF_CNT_BITS,
  parameter int unsigned CHK_LOG2     = DEF_CHK_LOG2,
  parameter int unsigned WDOG_CYCLES  = DEF_WDOG_CYCLES,
  parameter int unsigned FLUSH_CYCLES = DEF_FLUSH_CYCLES
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_job_val,
  output logic                o_job_rdy,
  input  redun0_t             i_job_sq,
  input  logic [CNT_BITS-1:0] i_job_iters,
  input  logic                i_abort,
  output logic                o_res_val,
  input  logic                i_res_rdy,
  output redun0_t             o_res,
  output logic [CNT_BITS-1:0] o_res_iters,
  output seq_err_t            o_res_err,
  output logic                o_chk_val,
  output redun0_t             o_chk,
  output logic                o_busy,
  output logic                o_dp_rst,
  output logic                o_dp_val,
  output redun0_t             o_dp_sq,
  input  logic                i_dp_val,
  input  redun0_t             i_dp_mul
);

  localparam logic [CNT_BITS-1:0] CHK_MASK = ~({CNT_BITS{1'b1}} << CHK_LOG2);

  seq_state_t          state_q;
  logic [CNT_BITS-1:0] iters_q;
  logic [CNT_BITS-1:0] done_cnt;
  logic [CNT_BITS-1:0] cnt_inc;
  logic [CNT_BITS-1:0] done_nxt;
  logic                chk_hit;
  logic                fin;
  logic                wdog_term;
  logic                flush_term;

  assign cnt_inc  = done_cnt + CNT_BITS'(1);
  assign done_nxt = i_dp_val ? cnt_inc : done_cnt;
  assign chk_hit  = (CHK_LOG2 != 0) && ((cnt_inc & CHK_MASK) == '0);
  assign fin      = i_dp_val && (cnt_inc == iters_q);

  // Watchdog restarts on every strobe and only runs in RUN.
  seq_wdog_cnt #(
    .WIDTH($clog2(WDOG_CYCLES + 1)),
    .TERM (WDOG_CYCLES - 1)
  ) u_wdog (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_clr ((state_q != StRun) || i_dp_val),
    .i_inc (state_q == StRun),
    .o_term(wdog_term)
  );

  seq_wdog_cnt #(
    .WIDTH($clog2(FLUSH_CYCLES + 1)),
    .TERM (FLUSH_CYCLES - 1)
  ) u_flush (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_clr (state_q != StFlush),
    .i_inc (state_q == StFlush),
    .o_term(flush_term)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= StFlush;
      o_job_rdy <= 1'b0;
      o_res_val <= 1'b0;
      o_res_err <= SeqOk;
      o_chk_val <= 1'b0;
      o_dp_val  <= 1'b0;
      o_busy    <= 1'b1;
      o_dp_rst  <= 1'b1;
    end else begin
      o_chk_val <= 1'b0;
      o_dp_val  <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (i_job_val) begin
            iters_q     <= i_job_iters;
            done_cnt    <= '0;
            o_res       <= i_job_sq;
            o_res_iters <= '0;
            o_res_err   <= SeqOk;
            o_dp_sq     <= i_job_sq;
            o_job_rdy   <= 1'b0;
            o_busy      <= 1'b1;
            if (i_job_iters == '0) begin
              state_q   <= StResult;
              o_res_val <= 1'b1;
            end else begin
              state_q  <= StLoad;
              o_dp_rst <= 1'b0;
              o_dp_val <= 1'b1;
            end
          end
        end
        StLoad: begin
          if (i_abort) begin
            state_q     <= StResult;
            o_res_val   <= 1'b1;
            o_res_err   <= SeqAbort;
            o_res_iters <= done_cnt;
            o_dp_rst    <= 1'b1;
          end else begin
            state_q <= StRun;
          end
        end
        StRun: begin
          if (i_dp_val) begin
            done_cnt <= cnt_inc;
            o_res    <= i_dp_mul;
            if (chk_hit) begin
              o_chk_val <= 1'b1;
              o_chk     <= i_dp_mul;
            end
          end
          // Completion takes priority over a coincident abort.
          if (fin || i_abort || (!i_dp_val && wdog_term)) begin
            state_q     <= StResult;
            o_res_val   <= 1'b1;
            o_dp_rst    <= 1'b1;
            o_res_iters <= done_nxt;
            if (fin) begin
              o_res_err <= SeqOk;
            end else if (i_abort) begin
              o_res_err <= SeqAbort;
            end else begin
              o_res_err <= SeqWdog;
            end
          end
        end
        StResult: begin
          if (i_res_rdy) begin
            state_q   <= StFlush;
            o_res_val <= 1'b0;
          end
        end
        StFlush: begin
          if (flush_term) begin
            state_q   <= StIdle;
            o_job_rdy <= 1'b1;
            o_busy    <= 1'b0;
          end
        end
        default: state_q <= StFlush;
      endcase
    end
  end

endmodule
